serial_word_rx: RTL



---
 rtl/serial_word_rx_if.sv | 41 ++++
 rtl/serial_word_rx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_word_rx_if.sv
// ----------------------------------------------------------------------------
// serial_word_rx_if
//   Bundles the serial-side inputs and the parallel valid/ready output of the
//   bit-serial word receiver.
//   Parameter:
//     WIDTH       data bits per frame
//   Signals:
//     sin         serial line, idle level 1
//     bit_en      bit strobe; sin is meaningful only when high
//     dout        received word, LSB = first data bit
//     dout_valid  dout holds an unconsumed word
//     dout_ready  consumer accepts dout this cycle
//     frame_err   one-cycle pulse: stop bit sampled as 0
//     overrun     one-cycle pulse: completed word dropped
//     parity_err  one-cycle pulse: parity mismatch
//   Modports:
//     master      drives the line and consumes the word (bench / upstream)
//     slave       the receiver itself
// ----------------------------------------------------------------------------
interface serial_word_rx_if #(
    parameter int WIDTH = 16
);
    logic             sin;
    logic             bit_en;
    logic             dout_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
    logic             overrun;
    logic             parity_err;

    modport master (
        output sin, bit_en, dout_ready,
        input  dout, dout_valid, frame_err, overrun, parity_err
    );

    modport slave (
        input  sin, bit_en, dout_ready,
        output dout, dout_valid, frame_err, overrun, parity_err
    );
endinterface

// File: rtl/serial_word_rx.sv
// ----------------------------------------------------------------------------
// serial_word_rx
//   Bit-serial word receiver. Samples a start(0) / WIDTH data bits (LSB first)
//   / [parity] / stop(1) frame, one bit per bit_en cycle, and presents the
//   assembled word on a valid/ready output. Cycles with bit_en=0 leave all
//   frame state untouched.
//
//   Optional feature macro: SERIAL_RX_PARITY_EN
//     defined   : one even-parity bit follows the data; mismatch pulses
//                 parity_err and discards the word.
//     undefined : stop bit follows the last data bit; parity_err is tied 0.
//
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    serial_word_rx_if.slave (sin, bit_en, dout_ready in;
//            dout, dout_valid, frame_err, overrun, parity_err out)
// ----------------------------------------------------------------------------
module serial_word_rx #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_rx_if.slave      bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
`ifdef SERIAL_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    logic             parity_q;     // running XOR of data and parity bits
    logic             parity_err_q;
`endif

    // NOTE: every state register below is assigned with <= so all of them
    // update together from pre-edge values; a blocking = here would let later
    // statements see already-updated state and reorder the logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_q     <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            // Error flags are single-cycle pulses; they only go high below.
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif

            // Consumer handshake. A completion in the same cycle overrides
            // this clear further down (last assignment wins).
            if (dout_valid_q && bus.dout_ready) begin
                dout_valid_q <= 1'b0;
            end

            if (bus.bit_en) begin
                case (state_q)
                    S_IDLE: begin
                        if (!bus.sin) begin
                            state_q  <= S_DATA;
                            cnt_q    <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            parity_q <= 1'b0;
`endif
                        end
                    end

                    S_DATA: begin
                        shift_q[cnt_q] <= bus.sin;
`ifdef SERIAL_RX_PARITY_EN
                        parity_q <= parity_q ^ bus.sin;
`endif
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            cnt_q   <= '0;
`ifdef SERIAL_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end

`ifdef SERIAL_RX_PARITY_EN
                    S_PARITY: begin
                        parity_q <= parity_q ^ bus.sin;
                        state_q  <= S_STOP;
                    end
`endif

                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (!bus.sin) begin
                            // Framing error wins over any parity mismatch.
                            frame_err_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                        end else if (parity_q) begin
                            parity_err_q <= 1'b1;
`endif
                        end else if (!dout_valid_q || bus.dout_ready) begin
                            // Slot is free, or being freed this very cycle.
                            dout_q       <= shift_q;
                            dout_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end

                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule
